// File: rtl/wb_write_arbiter.sv
// Write-side front end for the register file: merges pipeline writebacks and
// queued long-latency results onto one registered write port, with forwarding.
module wb_write_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_wa,
    input  logic [31:0]              pipe_wd,
    input  logic                     aux_valid,
    output logic                     aux_ready,
    input  logic [4:0]               aux_wa,
    input  logic [31:0]              aux_wd,
    output logic                     we3,
    output logic [4:0]               wa3,
    output logic [31:0]              wd3,
    input  logic [4:0]               ra1,
    input  logic [4:0]               ra2,
    output logic                     fwd1_hit,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd1_data,
    output logic [31:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]   pending_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] val_q, val_d;
    logic [4:0]       wa_q [DEPTH];
    logic [4:0]       wa_d [DEPTH];
    logic [31:0]      wd_q [DEPTH];
    logic [31:0]      wd_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             we3_q, we3_d;
    logic [4:0]       wa3_q, wa3_d;
    logic [31:0]      wd3_q, wd3_d;

    logic pipe_iss;
    logic accept;
    logic push;
    logic pop;

    assign aux_ready   = count_q < CW'(DEPTH);
    assign pending_cnt = count_q;
    assign we3         = we3_q;
    assign wa3         = wa3_q;
    assign wd3         = wd3_q;

    always_comb begin
        pipe_iss = pipe_we && (pipe_wa != 5'd0);
        accept   = aux_valid && aux_ready;
        push     = accept && (aux_wa != 5'd0);
        pop      = !pipe_iss && (count_q != '0);

        val_d    = val_q;
        wa_d     = wa_q;
        wd_d     = wd_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        we3_d    = 1'b0;
        wa3_d    = wa3_q;
        wd3_d    = wd3_q;

        if (pipe_iss) begin
            we3_d = 1'b1;
            wa3_d = pipe_wa;
            wd3_d = pipe_wd;
            // The pipeline write is younger than anything queued.
            for (int i = 0; i < DEPTH; i++) begin
                if (wa_q[i] == pipe_wa) begin
                    val_d[i] = 1'b0;
                end
            end
        end else if (pop) begin
            we3_d           = val_q[rd_ptr_q];
            wa3_d           = wa_q[rd_ptr_q];
            wd3_d           = wd_q[rd_ptr_q];
            val_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end

        if (push) begin
            val_d[wr_ptr_q] = !(pipe_iss && (aux_wa == pipe_wa));
            wa_d[wr_ptr_q]  = aux_wa;
            wd_d[wr_ptr_q]  = aux_wd;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            val_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            wa3_q    <= 5'd0;
            wd3_q    <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                wa_q[i] <= 5'd0;
                wd_q[i] <= 32'd0;
            end
        end else begin
            val_q    <= val_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
        end
    end

    // Scan oldest to newest so the newest valid match wins.
    always_comb begin
        logic [AW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr_q + AW'(i);
            if (val_q[idx] && (wa_q[idx] == ra1)) begin
                fwd1_hit  = 1'b1;
                fwd1_data = wd_q[idx];
            end
            if (val_q[idx] && (wa_q[idx] == ra2)) begin
                fwd2_hit  = 1'b1;
                fwd2_data = wd_q[idx];
            end
        end
        if (!fwd1_hit && we3_q && (wa3_q == ra1)) begin
            fwd1_hit  = 1'b1;
            fwd1_data = wd3_q;
        end
        if (!fwd2_hit && we3_q && (wa3_q == ra2)) begin
            fwd2_hit  = 1'b1;
            fwd2_data = wd3_q;
        end
        if (ra1 == 5'd0) begin
            fwd1_hit  = 1'b0;
            fwd1_data = 32'd0;
        end
        if (ra2 == 5'd0) begin
            fwd2_hit  = 1'b0;
            fwd2_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Randomized and directed bench for wb_write_arbiter against a queue-based
// reference model.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pipe_we = 1'b0;
    logic [4:0]    pipe_wa = '0;
    logic [31:0]   pipe_wd = '0;
    logic          aux_valid = 1'b0;
    logic          aux_ready;
    logic [4:0]    aux_wa = '0;
    logic [31:0]   aux_wd = '0;
    logic          we3;
    logic [4:0]    wa3;
    logic [31:0]   wd3;
    logic [4:0]    ra1 = '0;
    logic [4:0]    ra2 = '0;
    logic          fwd1_hit, fwd2_hit;
    logic [31:0]   fwd1_data, fwd2_data;
    logic [CW-1:0] pending_cnt;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_wa(aux_wa), .aux_wd(aux_wd),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t        q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void mfwd(input logic [4:0] ra, output logic hit,
                                 output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        if (ra != 5'd0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (!hit && q[i].v && q[i].wa == ra) begin
                    hit = 1'b1;
                    d   = q[i].wd;
                end
            end
            if (!hit && m_we && m_wa == ra) begin
                hit = 1'b1;
                d   = m_wd;
            end
        end
    endfunction

    task automatic check_outputs();
        logic        h;
        logic [31:0] d;
        chk("we3", 32'(we3), 32'(m_we));
        if (m_we) begin
            chk("wa3", 32'(wa3), 32'(m_wa));
            chk("wd3", wd3, m_wd);
        end
        chk("aux_ready", 32'(aux_ready), 32'(q.size() < DEPTH));
        chk("pending_cnt", 32'(pending_cnt), 32'(q.size()));
        mfwd(ra1, h, d);
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
        chk("fwd1_data", fwd1_data, d);
        mfwd(ra2, h, d);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
        chk("fwd2_data", fwd2_data, d);
    endtask

    task automatic model_step();
        logic ready;
        logic piss;
        ent_t e;
        ready = q.size() < DEPTH;
        piss  = pipe_we && pipe_wa != 5'd0;
        if (piss) begin
            m_we = 1'b1;
            m_wa = pipe_wa;
            m_wd = pipe_wd;
            foreach (q[i]) if (q[i].wa == pipe_wa) q[i].v = 1'b0;
        end else if (q.size() > 0) begin
            e    = q.pop_front();
            m_we = e.v;
            m_wa = e.wa;
            m_wd = e.wd;
        end else begin
            m_we = 1'b0;
        end
        if (aux_valid && ready && aux_wa != 5'd0) begin
            e.v  = !(piss && aux_wa == pipe_wa);
            e.wa = aux_wa;
            e.wd = aux_wd;
            q.push_back(e);
        end
    endtask

    task automatic cycle(input logic pwe, input logic [4:0] pwa,
                         input logic [31:0] pwd, input logic av,
                         input logic [4:0] awa, input logic [31:0] awd,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        pipe_we   = pwe;
        pipe_wa   = pwa;
        pipe_wd   = pwd;
        aux_valid = av;
        aux_wa    = awa;
        aux_wd    = awd;
        ra1       = r1;
        ra2       = r2;
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic idle(input int n, input logic [4:0] r1,
                        input logic [4:0] r2);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        ra1 = 5'd3;
        ra2 = 5'd5;
        repeat (2) @(negedge clk);
        chk("rst_we3", 32'(we3), 0);
        chk("rst_wa3", 32'(wa3), 0);
        chk("rst_wd3", wd3, 0);
        chk("rst_ready", 32'(aux_ready), 1);
        chk("rst_pending", 32'(pending_cnt), 0);
        chk("rst_fwd1", 32'(fwd1_hit), 0);
        chk("rst_fwd2", 32'(fwd2_hit), 0);
        resetn = 1'b1;

        // Pipeline write and forward from output register
        cycle(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 5, 0);
        chk("pipe_we3", 32'(we3), 1);
        chk("pipe_fwd", fwd1_data, 32'h1234);
        idle(1, 5, 5);

        // Fill and back-pressure
        cycle(1, 1, 32'h1, 1, 2, 32'h20, 0, 0);
        cycle(1, 1, 32'h1, 1, 3, 32'h30, 2, 3);
        cycle(1, 1, 32'h1, 1, 4, 32'h40, 3, 4);
        cycle(1, 1, 32'h1, 1, 5, 32'h50, 4, 5);
        cycle(1, 1, 32'h1, 1, 6, 32'h60, 5, 6);
        chk("full_ready", 32'(aux_ready), 0);
        chk("full_cnt", 32'(pending_cnt), 4);
        idle(6, 2, 5);

        // Squash
        cycle(1, 1, 32'h1, 1, 7, 32'hAAAA, 0, 7);
        cycle(1, 7, 32'hBBBB, 0, 0, 0, 0, 7);
        idle(3, 7, 7);

        // Forwarding priority
        cycle(1, 1, 32'h1, 1, 9, 32'h11, 9, 0);
        cycle(1, 1, 32'h1, 1, 9, 32'h22, 9, 0);
        cycle(1, 1, 32'h1, 0, 0, 0, 9, 9);
        cycle(0, 0, 0, 0, 0, 0, 9, 9);
        cycle(0, 0, 0, 0, 0, 0, 9, 9);
        chk("prio_fwd", fwd1_data, 32'h22);
        idle(2, 9, 9);

        // r0 handling
        cycle(0, 0, 0, 1, 0, 32'hFF, 0, 0);
        cycle(1, 1, 32'h1, 1, 3, 32'h33, 0, 3);
        cycle(1, 0, 32'h9, 0, 0, 0, 0, 3);
        cycle(0, 0, 0, 0, 0, 0, 0, 3);
        idle(2, 3, 0);

        // Reset mid-operation with three entries pending
        cycle(1, 1, 32'h1, 1, 10, 32'hA0, 0, 0);
        cycle(1, 1, 32'h1, 1, 11, 32'hB0, 10, 11);
        cycle(1, 1, 32'h1, 1, 12, 32'hC0, 11, 12);
        @(posedge clk);
        #2;
        pipe_we   = 1'b0;
        aux_valid = 1'b0;
        ra1       = 5'd10;
        resetn    = 1'b0;
        #1;
        chk("mrst_we3", 32'(we3), 0);
        chk("mrst_pending", 32'(pending_cnt), 0);
        chk("mrst_ready", 32'(aux_ready), 1);
        chk("mrst_fwd1", 32'(fwd1_hit), 0);
        q.delete();
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        @(negedge clk);
        resetn = 1'b1;
        idle(4, 10, 12);

        // Randomized traffic with varying pipeline pressure
        for (int ph = 0; ph < 12; ph++) begin
            int pct;
            pct = (ph % 3 == 0) ? 10 : ((ph % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 150; i++) begin
                cycle($urandom_range(0, 99) < pct,
                      5'($urandom_range(0, 7)), $urandom,
                      $urandom_range(0, 99) < 60,
                      5'($urandom_range(0, 7)), $urandom,
                      5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)));
            end
        end
        idle(8, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
